// File: rtl/cmp_unit.sv
// Chunked MSB-first relational compare; out_valid NCHUNK cycles after accept (earlier with EARLY_EXIT).
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module cmp_unit #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LTZ = 3'b010;
    localparam logic [2:0] OP_GEZ = 3'b011;
    localparam logic [2:0] OP_LEZ = 3'b100;
    localparam logic [2:0] OP_GTZ = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             eq_q, eq_d, lt_q, lt_d;
    logic             res_q, res_d;

    logic [CHUNK-1:0] a_top, b_top;
    logic             differs, zero_op;
    logic [WIDTH-1:0] msb_flip;

    function automatic logic eval_res(input logic [2:0] op, input logic eq, input logic lt);
        case (op)
            OP_EQ:         eval_res = eq;
            OP_NE:         eval_res = !eq;
            OP_LTZ, OP_LT: eval_res = lt;
            OP_LEZ:        eval_res = lt | eq;
            OP_GTZ:        eval_res = !(lt | eq);
            default:       eval_res = !lt;
        endcase
    endfunction

    // Operands are pre-biased at capture (sign flip, zeroed B) so RUN is a plain unsigned compare.
    assign a_top    = a_q[WIDTH-1 -: CHUNK];
    assign b_top    = b_q[WIDTH-1 -: CHUNK];
    assign differs  = (a_top != b_top);
    assign zero_op  = (Op >= OP_LTZ) && (Op <= OP_GTZ);
    assign msb_flip = {Sign, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A ^ msb_flip;
                    b_d     = (zero_op ? '0 : B) ^ msb_flip;
                    op_d    = Op;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    cnt_d   = CW'(NCHUNK - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d = a_q << CHUNK;
                b_d = b_q << CHUNK;
                if (eq_q && differs) begin
                    eq_d = 1'b0;
                    lt_d = (a_top < b_top);
                end
                if (cnt_q == '0 || (EARLY_EXIT != 0 && eq_q && differs)) begin
                    res_d   = eval_res(op_q, eq_d, lt_d);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = {{(WIDTH-1){1'b0}}, res_q};
    assign Z         = !res_q;
    assign V         = 1'b0;
    assign N         = 1'b0;
endmodule

// File: tb/tb_cmp_unit.sv
// Directed vectors on two instances (EARLY_EXIT 0 and 1) sharing stimulus.
module tb_cmp_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, sgn;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        ir0, ov0, z0, v0, n0, ir1, ov1, z1, v1, n1;
    logic [31:0] s0, s1;

    int total = 0;
    int bad   = 0;
    int lat0, lat1;
    logic [31:0] r_s0, r_s1;
    logic        r_z0, r_z1;

    always #5 clk = ~clk;

    cmp_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .A(a), .B(b), .Op(op), .Sign(sgn), .out_valid(ov0), .out_ready(out_ready),
        .S(s0), .Z(z0), .V(v0), .N(n0));

    cmp_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .A(a), .B(b), .Op(op), .Sign(sgn), .out_valid(ov1), .out_ready(out_ready),
        .S(s1), .Z(z1), .V(v1), .N(n1));

    typedef struct {
        logic [2:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_s;
        int          exp_lat1;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] o, input logic sg, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        chk("in_ready_before_accept", {31'b0, ir0 & ir1}, 1);
        op = o; sgn = sg; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; op = 3'd0; sgn = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic sg, input logic [31:0] av, input logic [31:0] bv);
        start_op(o, sg, av, bv);
        lat0 = 0;
        lat1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (ov1 && lat1 == 0) lat1 = c;
            if (ov0 && lat0 == 0) lat0 = c;
            if (lat0 != 0 && lat1 != 0) break;
        end
        r_s0 = s0; r_z0 = z0; r_s1 = s1; r_z1 = z1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_xfer", {30'b0, ir1, ir0}, 3);
        chk("out_valid_after_xfer", {30'b0, ov1, ov0}, 0);
    endtask

    initial begin
        vecs[0]  = '{3'd5, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[1]  = '{3'd5, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[2]  = '{3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1};
        vecs[3]  = '{3'd6, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1};
        vecs[4]  = '{3'd0, 1'b0, 32'h1234_5678, 32'h1234_5679, 1'b0, 4};
        vecs[5]  = '{3'd0, 1'b0, 32'h1300_0000, 32'h1234_5678, 1'b0, 1};
        vecs[6]  = '{3'd4, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b1, 4};
        vecs[7]  = '{3'd3, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[8]  = '{3'd1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
        vecs[9]  = '{3'd7, 1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1};
        vecs[10] = '{3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
        vecs[11] = '{3'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[12] = '{3'd0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 4};
        vecs[13] = '{3'd6, 1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1, 4};
        vecs[14] = '{3'd7, 1'b0, 32'h0001_0000, 32'h0002_0000, 1'b0, 2};
        vecs[15] = '{3'd4, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 4};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; sgn = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, ir0}, 1);
        chk("rst_out_valid", {31'b0, ov0}, 0);
        chk("rst_S", s0, 0);
        chk("rst_ZVN", {29'b0, z0, v0, n0}, 3'b100);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_S_ee0", i), r_s0, {31'b0, vecs[i].exp_s});
            chk($sformatf("v%0d_Z_ee0", i), {31'b0, r_z0}, {31'b0, !vecs[i].exp_s});
            chk($sformatf("v%0d_lat_ee0", i), lat0, 4);
            chk($sformatf("v%0d_S_ee1", i), r_s1, {31'b0, vecs[i].exp_s});
            chk($sformatf("v%0d_Z_ee1", i), {31'b0, r_z1}, {31'b0, !vecs[i].exp_s});
            chk($sformatf("v%0d_lat_ee1", i), lat1, vecs[i].exp_lat1);
            chk($sformatf("v%0d_VN", i), {28'b0, v0, n0, v1, n1}, 0);
            release_out();
        end

        // Output backpressure with a stray request while in DONE.
        run_op(3'd5, 1'b0, 32'h8000_0000, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                in_valid = 1'b1; op = 3'd0; a = 32'h1; b = 32'h2;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            chk($sformatf("bp%0d_out_valid", k), {30'b0, ov1, ov0}, 3);
            chk($sformatf("bp%0d_S", k), {s1[15:0], s0[15:0]}, 32'h0001_0001);
            chk($sformatf("bp%0d_Z", k), {30'b0, z1, z0}, 0);
            chk($sformatf("bp%0d_in_ready", k), {30'b0, ir1, ir0}, 0);
        end
        release_out();
        @(posedge clk);
        #1;
        chk("bp_stray_not_accepted", {28'b0, ov1, ov0, ir1, ir0}, 4'b0011);
        chk("bp_result_kept_idle", s0, 1);

        // Reset in the second RUN cycle discards the in-flight op.
        start_op(3'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {30'b0, ov1, ov0}, 0);
        chk("mid_rst_S", {s1[15:0], s0[15:0]}, 0);
        chk("mid_rst_Z", {30'b0, z1, z0}, 3);
        chk("mid_rst_in_ready", {30'b0, ir1, ir0}, 3);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd7, 1'b1, 32'h0000_0005, 32'hFFFF_FFFD);
        chk("post_rst_GE_S_ee0", r_s0, 1);
        chk("post_rst_GE_S_ee1", r_s1, 1);
        chk("post_rst_GE_lat_ee0", lat0, 4);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmp_unit.md
# cmp_unit

Multi-cycle, parametrised compare/condition unit for the ALU and branch-resolution path. It evaluates one of eight relational conditions (EQ, NE, LTZ, GEZ, LEZ, GTZ, LT, GE) on WIDTH-bit operands, signed or unsigned. It processes the operands MSB-first, CHUNK bits per cycle, and returns a 0/1 result word with the standard Z/V/N flag set. A valid/ready handshake sits on both sides, and early termination is optional.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK
- EARLY_EXIT, 0, when 1 the unit finishes as soon as the outcome is decided
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request; high only in IDLE
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B; ignored for zero-compare ops
- Op  input  3  000 EQ, 001 NE, 010 LTZ, 011 GEZ, 100 LEZ, 101 GTZ, 110 LT, 111 GE
- Sign  input  1  1 = signed (two's complement), 0 = unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  result, {WIDTH-1 zeros, res}
- Z  output  1  1 when S == 0
- V  output  1  always 0
- N  output  1  always 0

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: a chunk counter runs from NCHUNK-1 down to 0.
  - DONE: out_valid=1.
- IDLE -> RUN on in_valid && in_ready. At that edge A, B, Op and Sign are captured. Input changes afterwards are ignored.
- Bx = 0 for Op 010–101; otherwise Bx = B.
- Each RUN cycle compares chunk i of A against chunk i of Bx, MSB chunk first.
- Signed mode: the MSB of both operands is inverted in the first chunk, then the compare is unsigned.
- Running state:
  - while no difference has been seen, eq stays 1;
  - the first differing chunk sets eq=0 and sets lt = (A chunk < Bx chunk);
  - later chunks do not change lt.
- res by op:
  - EQ: eq
  - NE: !eq
  - LTZ and LT: lt
  - GEZ and GE: !lt
  - LEZ: lt|eq
  - GTZ: !(lt|eq)
- Unsigned LTZ is always 0. Unsigned GTZ is A != 0.
- RUN -> DONE after the chunk-0 edge, or, with EARLY_EXIT=1, after the first edge whose chunk differs.
- DONE -> IDLE on out_ready. S, Z, V and N are registered and stay stable throughout DONE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, S 0, Z 1, V 0, N 0, counter 0.
- Reset acts immediately when asserted, including mid-RUN or in DONE. Any in-flight result is discarded.
- Latency with EARLY_EXIT=0: out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles for 32/8).
- Latency with EARLY_EXIT=1: out_valid rises j+1 cycles after acceptance, where j is the number of leading equal chunks; the maximum is NCHUNK.
- If CHUNK = WIDTH, latency is 1.
- A result transfers on the edge where out_valid && out_ready. in_ready rises the following cycle; there is no same-cycle turnaround.
- Throughput is at most one op per NCHUNK+2 cycles.
- in_valid during RUN or DONE is ignored. The requester must hold its request until in_ready.
- out_ready while out_valid=0 has no effect.
- S, Z, V and N update only on the RUN->DONE edge. They keep the last result through IDLE until the next DONE.

## Test plan
Configuration for all scenarios: WIDTH=32, CHUNK=8.

- **Unsigned vs signed GTZ:** GTZ, Sign=0, A=0x8000_0000 -> S=1, Z=0, out_valid 4 cycles after accept. Then the same A with Sign=1 -> S=0, Z=1.
- **Signedness of LT:** LT, A=0xFFFF_FFFF, B=0x0000_0001. Sign=1 -> S=1. Sign=0 -> S=0.
- **Early exit latency (EARLY_EXIT=1, EQ):**
  - A=0x1234_5678, B=0x1234_5679 -> S=0, latency 4;
  - A=0x1300_0000, B=0x1234_5678 -> S=0, latency 1;
  - with EARLY_EXIT=0, both cases have latency 4.
- **Zero-compare edges:** LEZ, Sign=1, A=0 -> S=1. GEZ, Sign=1, A=0x8000_0000 -> S=0. NE, A=B=0xDEAD_BEEF -> S=0, Z=1.
- **Output backpressure:** hold out_ready=0 for 5 cycles in DONE. S, Z and out_valid stay stable and in_ready stays 0. A new in_valid pulse is not accepted. After out_ready=1, in_ready=1 on the next cycle.
- **Reset mid-operation:** assert reset in the 2nd RUN cycle. out_valid=0, S=0, Z=1 and in_ready=1 take effect immediately. After deassert, a GE op with Sign=1, A=5, B=-3 -> S=1.
